// File: rtl/acc_stream_pingpong_if.sv
// Signal bundle for acc_stream_pingpong: scatter-write port, control strobes and output stream.
// D_LAST is only present when OUT_BUF_LAST_EN is defined.
interface acc_stream_pingpong_if #(
  parameter int N        = 256,
  parameter int DW       = 16,
  parameter int CH       = 2,
  parameter int IDX_BITS = $clog2(N)
);

  logic                CLEAR;
  logic                SWAP;
  logic                WR_EN;
  logic [IDX_BITS-1:0] WR_IDX;
  logic [CH*DW-1:0]    WR_DATA;
  logic [DW-1:0]       DATA_OUT;
  logic                D_VALID;
  logic                D_READY;
  logic                BUSY;
  logic                DONE;
  logic                OVERRUN;
`ifdef OUT_BUF_LAST_EN
  logic                D_LAST;

  modport master (
    output CLEAR, SWAP, WR_EN, WR_IDX, WR_DATA, D_READY,
    input  DATA_OUT, D_VALID, BUSY, DONE, OVERRUN, D_LAST
  );

  modport slave (
    input  CLEAR, SWAP, WR_EN, WR_IDX, WR_DATA, D_READY,
    output DATA_OUT, D_VALID, BUSY, DONE, OVERRUN, D_LAST
  );
`else
  modport master (
    output CLEAR, SWAP, WR_EN, WR_IDX, WR_DATA, D_READY,
    input  DATA_OUT, D_VALID, BUSY, DONE, OVERRUN
  );

  modport slave (
    input  CLEAR, SWAP, WR_EN, WR_IDX, WR_DATA, D_READY,
    output DATA_OUT, D_VALID, BUSY, DONE, OVERRUN
  );
`endif

endinterface

// File: rtl/acc_stream_pingpong.sv
// Ping-pong acceleration buffer: one bank takes scatter writes while the other streams out word by word.
// Defining OUT_BUF_LAST_EN adds a registered D_LAST marker on the final word of each frame.
module acc_stream_pingpong #(
  parameter int N        = 256,
  parameter int DW       = 16,
  parameter int CH       = 2,
  parameter int IDX_BITS = $clog2(N)
) (
  input logic                  CLK_IN,
  input logic                  RESET_IN,
  acc_stream_pingpong_if.slave bus
);

  localparam int                  CH_BITS  = (CH > 1) ? $clog2(CH) : 1;
  localparam logic [IDX_BITS-1:0] IDX_LAST = IDX_BITS'(N - 1);
  localparam logic [CH_BITS-1:0]  CH_LAST  = CH_BITS'(CH - 1);

  typedef enum logic {
    IDLE   = 1'b0,
    STREAM = 1'b1
  } state_t;

  state_t              state_q, state_d;
  logic                wr_bank_q, wr_bank_d;
  logic [IDX_BITS-1:0] idx_q, idx_d, idx_nx;
  logic [CH_BITS-1:0]  ch_q, ch_d, ch_nx;
  logic [DW-1:0]       data_q, data_d;
  logic                valid_q, valid_d;
  logic                done_q, done_d;
  logic                overrun_q, overrun_d;
`ifdef OUT_BUF_LAST_EN
  logic                last_q, last_d;
`endif

  logic                rd_bank;
  logic                fire;
  logic                final_word;
  logic                start_frame;
  logic [DW-1:0]       first_word;

  logic [DW-1:0]       mem [2][N][CH];

  assign rd_bank    = ~wr_bank_q;
  assign fire       = valid_q & bus.D_READY;
  assign final_word = (idx_q == IDX_LAST) && (ch_q == CH_LAST);

  // The bank being committed may take a write to body 0 on the same edge; forward it.
  assign first_word = (bus.WR_EN && (bus.WR_IDX == '0)) ? bus.WR_DATA[DW-1:0]
                                                         : mem[wr_bank_q][0][0];

  always_ff @(posedge CLK_IN) begin
    if (bus.WR_EN) begin
      for (int c = 0; c < CH; c++) begin
        mem[wr_bank_q][bus.WR_IDX][c] <= bus.WR_DATA[c*DW +: DW];
      end
    end
  end

  always_comb begin
    ch_nx  = ch_q + 1'b1;
    idx_nx = idx_q;
    if (ch_q == CH_LAST) begin
      ch_nx  = '0;
      idx_nx = idx_q + 1'b1;
    end
  end

  always_comb begin
    state_d     = state_q;
    wr_bank_d   = wr_bank_q;
    idx_d       = idx_q;
    ch_d        = ch_q;
    data_d      = data_q;
    valid_d     = valid_q;
    done_d      = 1'b0;
    overrun_d   = overrun_q;
    start_frame = 1'b0;
`ifdef OUT_BUF_LAST_EN
    last_d      = last_q;
`endif

    if (bus.CLEAR) begin
      state_d   = IDLE;
      idx_d     = '0;
      ch_d      = '0;
      valid_d   = 1'b0;
      overrun_d = 1'b0;
`ifdef OUT_BUF_LAST_EN
      last_d    = 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          start_frame = bus.SWAP;
        end
        STREAM: begin
          if (fire && final_word) begin
            done_d = 1'b1;
            if (bus.SWAP) begin
              start_frame = 1'b1;
            end else begin
              state_d = IDLE;
              valid_d = 1'b0;
              idx_d   = '0;
              ch_d    = '0;
`ifdef OUT_BUF_LAST_EN
              last_d  = 1'b0;
`endif
            end
          end else begin
            // A commit is only possible when the current frame is finishing.
            if (bus.SWAP) begin
              overrun_d = 1'b1;
            end
            if (fire) begin
              idx_d  = idx_nx;
              ch_d   = ch_nx;
              data_d = mem[rd_bank][idx_nx][ch_nx];
`ifdef OUT_BUF_LAST_EN
              last_d = (idx_nx == IDX_LAST) && (ch_nx == CH_LAST);
`endif
            end
          end
        end
        default: begin
          state_d = IDLE;
        end
      endcase

      if (start_frame) begin
        wr_bank_d = ~wr_bank_q;
        idx_d     = '0;
        ch_d      = '0;
        data_d    = first_word;
        valid_d   = 1'b1;
        state_d   = STREAM;
`ifdef OUT_BUF_LAST_EN
        last_d    = 1'b0;
`endif
      end
    end
  end

  always_ff @(posedge CLK_IN or negedge RESET_IN) begin
    if (!RESET_IN) begin
      state_q   <= IDLE;
      wr_bank_q <= 1'b0;
      idx_q     <= '0;
      ch_q      <= '0;
      data_q    <= '0;
      valid_q   <= 1'b0;
      done_q    <= 1'b0;
      overrun_q <= 1'b0;
`ifdef OUT_BUF_LAST_EN
      last_q    <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      wr_bank_q <= wr_bank_d;
      idx_q     <= idx_d;
      ch_q      <= ch_d;
      data_q    <= data_d;
      valid_q   <= valid_d;
      done_q    <= done_d;
      overrun_q <= overrun_d;
`ifdef OUT_BUF_LAST_EN
      last_q    <= last_d;
`endif
    end
  end

  assign bus.DATA_OUT = data_q;
  assign bus.D_VALID  = valid_q;
  assign bus.BUSY     = (state_q == STREAM);
  assign bus.DONE     = done_q;
  assign bus.OVERRUN  = overrun_q;
`ifdef OUT_BUF_LAST_EN
  assign bus.D_LAST   = last_q;
`endif

endmodule

// File: doc/acc_stream_pingpong.md
# acc_stream_pingpong

Double-buffered, parametrised output buffer for the force-computation pipeline: the compute core scatter-writes per-body accelerations (CH channels of DW bits each) into a write bank while the previously committed frame streams out of the other bank over a valid/ready interface. A SWAP strobe commits the write bank and starts its stream. The block sits between the compute core and the host/DMA stream, so computing frame k+1 overlaps with draining frame k.

## Interface
- N, 256, bodies per frame (≥2)
- DW, 16, bits per channel word
- CH, 2, channels per body (1..4; e.g. 2 = X,Y; 3 = X,Y,Z)
- IDX_BITS, $clog2(N), body index width
- CLK_IN  input  1  clock; all logic on rising edge
- RESET_IN  input  1  asynchronous, active-low reset
- CLEAR  input  1  synchronous abort of the read side, clears OVERRUN
- SWAP  input  1  commit write bank and start streaming it
- WR_EN  input  1  write strobe
- WR_IDX  input  IDX_BITS  body index
- WR_DATA  input  CH*DW  packed channels; channel 0 in bits [DW-1:0]
- DATA_OUT  output  DW  stream word
- D_VALID  output  1  DATA_OUT valid
- D_READY  input  1  sink ready
- BUSY  output  1  read side streaming
- DONE  output  1  one-cycle pulse on acceptance of the final word of a frame
- OVERRUN  output  1  sticky: SWAP arrived while BUSY
- D_LAST  output  1  only with OUT_BUF_LAST_EN; see Configuration

## Operation
- Storage: two banks, each N×CH words of DW bits, register array, not reset. wr_bank bit selects write bank; read bank = !wr_bank.
- Write: WR_EN writes all CH channels of WR_DATA to wr_bank[WR_IDX] in one cycle. Last write to same index in a frame wins.
- Read FSM, two states:
  - IDLE: D_VALID=0. On SWAP (and not CLEAR): toggle wr_bank, load output register with word (idx 0, ch 0) of the newly committed bank, go STREAM.
  - STREAM: D_VALID=1. On fire (D_VALID&&D_READY): advance ch; after ch=CH-1 wrap ch to 0 and advance idx; output register loads next word same edge. On fire of (idx N-1, ch CH-1): pulse DONE, D_VALID=0, go IDLE.
- Word order: idx 0..N-1 outer, channel 0..CH-1 inner; N*CH words per frame.
- SWAP while STREAM (not on the final-fire cycle): ignored, bank not toggled, OVERRUN set. SWAP coincident with the final fire: accepted; next frame starts directly (D_VALID stays 1, DONE still pulses).
- WR_EN coincident with SWAP: write lands in the pre-swap bank and is part of the committed frame.
- CLEAR: state→IDLE, counters→0, D_VALID→0, OVERRUN→0, DONE not pulsed, wr_bank unchanged, memory unchanged. CLEAR dominates SWAP in the same cycle.
- BUSY = (state==STREAM).

## Timing
- Reset values: D_VALID 0, DATA_OUT 0, DONE 0, BUSY 0, OVERRUN 0, D_LAST 0; state IDLE, wr_bank 0, idx/ch 0. Reset asserts asynchronously, mid-stream included; stream resumes only after a new SWAP.
- SWAP at edge t → D_VALID=1 with word 0 from edge t (visible cycle t+1).
- DATA_OUT, D_VALID, DONE, D_LAST all registered. DATA_OUT held stable while D_VALID && !D_READY.
- Throughput 1 word/cycle with D_READY held high; frame drains in N*CH cycles.
- DONE high exactly one cycle, the cycle after final fire.
- Write-to-stream latency: a write is visible only after the next accepted SWAP.

## Configuration
- OUT_BUF_LAST_EN defined: D_LAST port present, registered, high together with D_VALID on the frame's final word (idx N-1, ch CH-1), low otherwise.
- Undefined: D_LAST port and logic absent; all other behaviour identical.

## Test plan
- N=4, CH=2, DW=16: write idx i with X=0x100+i, Y=0x200+i, SWAP, D_READY=1 → 8 words 0x100,0x200,0x101,…,0x203 on consecutive cycles, DONE pulse one cycle after the 8th, BUSY low after.
- Same frame, D_READY toggling 1/0 each cycle → identical word sequence, DATA_OUT stable during stalls, 16 cycles total.
- During frame-0 stream, write frame 1 (0xA00+i) → frame-0 words unaffected; SWAP after DONE streams 0xA00… from other bank.
- SWAP mid-stream → ignored, OVERRUN=1, stream continues; CLEAR → D_VALID=0, OVERRUN=0, next SWAP re-streams same bank as before CLEAR? No: wr_bank toggles, streams bank last written.
- SWAP on final-fire cycle → DONE pulses, D_VALID stays 1, next frame word 0 follows with no gap; RESET_IN low mid-stream → all outputs 0 immediately.
- OUT_BUF_LAST_EN defined, N=4, CH=3 → D_LAST high only on 12th word.
